// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB fade sequencer: command byte layout,
// FSM state encoding, default timing values and the one-level step helper.
package rgb_pkg;

  // Host / PWM command byte layout
  localparam int MODE_BIT  = 7;
  localparam int COLOR_MSB = 6;
  localparam int COLOR_LSB = 4;
  localparam int LEVEL_MSB = 3;
  localparam int LEVEL_LSB = 0;

  // Default timing (clk cycles)
  localparam int DEF_STEP_CYCLES = 1_000_000;
  localparam int DEF_GAP_CYCLES  = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_GAP       = 2'd2,
    S_FADE_WAIT = 2'd3
  } state_t;

  // Move a 4-bit level one step toward target; saturates at target, never wraps.
  function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] target);
    if (target > cur) return cur + 4'd1;
    else if (target < cur) return cur - 4'd1;
    else return cur;
  endfunction

endpackage

// File: rtl/rgb_step_timer.sv
// Loadable down-counter. expired is high whenever the count has reached zero;
// a load restarts the count from load_val on the next cycle.
module rgb_step_timer #(
  parameter int STEP_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [$clog2(STEP_CYCLES+1)-1:0]   load_val,
  output logic                               expired
);
  localparam int W = $clog2(STEP_CYCLES + 1);

  logic [W-1:0] count;

  // Count down to zero and stay there until reloaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (count != '0) count <= count - W'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Turns host command bytes into PWM driver commands, either immediately or as
// a one-level-per-step fade, while keeping command pulses at least GAP_CYCLES
// apart so the PWM driver's two-cycle handshake never misses one.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; every byte is
// captured (no backpressure), a byte still pending when the next arrives is
// replaced and overrun pulses. cmd_valid is a one-cycle strobe qualifying
// cmd_out; the PWM side is assumed always ready given the enforced spacing.
module rgb_fade_sequencer
  import rgb_pkg::*;
#(
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] cmd_out,
  output logic       cmd_valid,
  output logic       busy,
  output logic       overrun
);
  localparam int TW = $clog2(STEP_CYCLES + 1);
  // Timer loaded in the ISSUE cycle expires on the last GAP cycle; reloaded
  // there it expires on the cycle before the next fade step is issued.
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 3);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(STEP_CYCLES - GAP_CYCLES);

  state_t      state;
  logic        pend_valid;
  logic [7:0]  pend_data;
  logic [2:0]  cur_color;
  logic [3:0]  cur_level;
  logic        fade_active;
  logic [3:0]  fade_target;

  logic        consume;
  logic [3:0]  pend_level;
  logic        pend_fade;
  logic [3:0]  first_level;
  logic [7:0]  consume_cmd;
  logic        timer_load;
  logic [TW-1:0] timer_val;
  logic        timer_expired;

  assign consume = (state == S_IDLE) && pend_valid;
  assign busy    = (state != S_IDLE) || pend_valid;

  // First command produced by the pending byte (a fade starts one step away)
  always_comb begin
    pend_level  = pend_data[LEVEL_MSB:LEVEL_LSB];
    pend_fade   = pend_data[MODE_BIT] && (pend_level != cur_level);
    first_level = pend_fade ? step_toward(cur_level, pend_level) : pend_level;
    consume_cmd = {1'b0, pend_data[COLOR_MSB:COLOR_LSB], first_level};
  end

  assign timer_load = (state == S_ISSUE) || ((state == S_GAP) && timer_expired);
  assign timer_val  = (state == S_ISSUE) ? GAP_LOAD : WAIT_LOAD;

  rgb_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  // One-deep pending byte; a byte replaced before consumption flags overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= rx_valid && pend_valid && !consume;
      if (rx_valid) begin
        pend_valid <= 1'b1;
        pend_data  <= rx_data;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Command sequencing FSM: issue, enforce spacing, step fades, allow preemption
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_out     <= '0;
      cmd_valid   <= 1'b0;
      cur_color   <= '0;
      cur_level   <= '0;
      fade_active <= 1'b0;
      fade_target <= '0;
    end else begin
      cmd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pend_valid) begin
            cmd_out     <= consume_cmd;
            cmd_valid   <= 1'b1;
            fade_active <= pend_fade;
            fade_target <= pend_level;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cur_color <= cmd_out[COLOR_MSB:COLOR_LSB];
          cur_level <= cmd_out[LEVEL_MSB:LEVEL_LSB];
          state     <= S_GAP;
        end
        S_GAP: begin
          if (timer_expired) begin
            if (pend_valid) begin
              state <= S_IDLE;
            end else if (fade_active && (cur_level != fade_target)) begin
              state <= S_FADE_WAIT;
            end else begin
              fade_active <= 1'b0;
              state       <= S_IDLE;
            end
          end
        end
        S_FADE_WAIT: begin
          if (pend_valid) begin
            state <= S_IDLE;
          end else if (timer_expired) begin
            cmd_out   <= {1'b0, cur_color, step_toward(cur_level, fade_target)};
            cmd_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer with STEP_CYCLES=16, GAP_CYCLES=4.
// A timing-rule model predicts every output each cycle; directed scenarios
// pin the model with literal pulse lists and cycle numbers.
module tb_rgb_fade_sequencer;
  localparam int STEP = 16;
  localparam int GAP  = 4;
  localparam int FAR  = -100000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] cmd_out;
  logic       cmd_valid, busy, overrun;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rgb_fade_sequencer #(.STEP_CYCLES(STEP), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd_out   (cmd_out),
    .cmd_valid (cmd_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_pend, m_prev_pend, m_fade_active, m_fade_cont, m_sched, m_ov;
  logic [7:0] m_pend_data, m_sched_data, m_cmd_out;
  int         m_cur_level, m_cur_color, m_target, m_last;
  bit         e_valid, e_busy, e_consume;

  // observed pulses
  logic [7:0] pd_q[$];
  int         pc_q[$];
  logic [7:0] exp_q[$];
  int         ov_cnt = 0;
  int         last_pulse = FAR;

  function automatic int toward(input int cur, input int tgt);
    return (tgt > cur) ? cur + 1 : cur - 1;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_prev_pend = 0; m_fade_active = 0; m_fade_cont = 0;
    m_sched = 0; m_ov = 0; m_pend_data = '0; m_sched_data = '0; m_cmd_out = '0;
    m_cur_level = 0; m_cur_color = 0; m_target = 0; m_last = FAR;
  endtask

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      last_pulse = FAR;
    end else begin
      // A pulse is due either one cycle after a consume, or STEP after the
      // last pulse of a running fade when no byte turned up to preempt it.
      e_valid = 0;
      if (m_sched) begin
        e_valid = 1; m_cmd_out = m_sched_data; m_sched = 0;
      end else if (m_fade_cont && cyc == m_last + STEP && !m_prev_pend) begin
        e_valid = 1;
        m_cmd_out = {1'b0, 3'(m_cur_color), 4'(toward(m_cur_level, m_target))};
      end
      if (e_valid) begin
        m_cur_color = int'(m_cmd_out[6:4]);
        m_cur_level = int'(m_cmd_out[3:0]);
        m_last = cyc;
        m_fade_cont = m_fade_active && (m_cur_level != m_target);
        if (!m_fade_cont) m_fade_active = 0;
      end
      e_busy = m_pend || m_fade_cont || (cyc <= m_last + GAP - 2);

      check("cmd_valid", 32'(cmd_valid), 32'(e_valid));
      check("cmd_out", 32'(cmd_out), 32'(m_cmd_out));
      check("busy", 32'(busy), 32'(e_busy));
      check("overrun", 32'(overrun), 32'(m_ov));

      if (cmd_valid) begin
        check("pulse_spacing_ok", 32'(cyc - last_pulse >= GAP), 32'd1);
        last_pulse = cyc;
        pd_q.push_back(cmd_out);
        pc_q.push_back(cyc);
      end
      if (overrun) ov_cnt++;

      // A pending byte is taken once the spacing window has passed; during a
      // running fade it must have been waiting at least one cycle already.
      if (m_fade_cont) e_consume = m_pend && m_prev_pend && (cyc >= m_last + GAP - 1);
      else             e_consume = m_pend && (cyc >= m_last + GAP - 1);
      if (e_consume) begin
        if (m_pend_data[7] && int'(m_pend_data[3:0]) != m_cur_level) begin
          m_fade_active = 1;
          m_target = int'(m_pend_data[3:0]);
          m_sched_data = {1'b0, m_pend_data[6:4], 4'(toward(m_cur_level, m_target))};
        end else begin
          m_fade_active = 0;
          m_sched_data = {1'b0, m_pend_data[6:0]};
        end
        m_sched = 1;
        m_fade_cont = 0;
      end
      m_ov = rx_valid && m_pend && !e_consume;
      m_prev_pend = m_pend;
      if (rx_valid) begin
        m_pend = 1; m_pend_data = rx_data;
      end else if (e_consume) begin
        m_pend = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_n(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    step_n(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin step_n(1); k++; end
    check("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (pd_q.size() < n && k < budget) begin step_n(1); k++; end
    check("pulses_within_budget", 32'(pd_q.size() >= n), 32'd1);
  endtask

  function automatic int pc_at(input int i);
    return (pc_q.size() > i) ? pc_q[i] : FAR;
  endfunction

  task automatic clear_q();
    pd_q.delete(); pc_q.delete(); exp_q.delete();
  endtask

  // Scoreboard: observed pulse list against the hand-written expected list
  task automatic check_pulses(input string name);
    check({name, "_count"}, 32'(pd_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < pd_q.size(); i++)
      check({name, "_data"}, 32'(pd_q[i]), 32'(exp_q[i]));
    clear_q();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0, ov0;
    model_reset();
    step_n(3);
    rst = 1'b0;
    check("reset_cmd_out", 32'(cmd_out), 32'h0);
    check("reset_cmd_valid", 32'(cmd_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    step_n(2);
    clear_q();

    // 1: immediate command
    exp_q.push_back(8'h5A);
    t0 = cyc;
    send(8'h5A);
    step_n(3);
    check("t1_busy_at_T4", 32'(busy), 32'd1);
    step_n(1);
    check("t1_busy_low_T5", 32'(busy), 32'd0);
    step_n(20);
    check("t1_pulse_cycle", 32'(pc_at(0)), 32'(t0 + 2));
    check_pulses("t1");

    // 2: fade up from 0, then fade down
    send(8'h00); wait_idle(20); clear_q();
    send(8'h93); wait_idle(100); step_n(5);
    check("t2_up_spacing_a", 32'(pc_at(1) - pc_at(0)), 32'd16);
    check("t2_up_spacing_b", 32'(pc_at(2) - pc_at(1)), 32'd16);
    exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13);
    check_pulses("t2_up");
    send(8'h90); wait_idle(100); step_n(5);
    exp_q.push_back(8'h12); exp_q.push_back(8'h11); exp_q.push_back(8'h10);
    check_pulses("t2_down");

    // 3: fade request equal to current level gives a single command
    send(8'h13); wait_idle(20); clear_q();
    send(8'hC3); wait_idle(40); step_n(40);
    exp_q.push_back(8'h43);
    check_pulses("t3");

    // 4: preempt a running fade
    send(8'h9F);
    wait_pulses(2, 100);
    t0 = cyc;
    send(8'h20);
    wait_idle(40); step_n(40);
    check("t4_latency", 32'((pc_at(2) > t0) && (pc_at(2) - t0 <= GAP + 2)), 32'd1);
    exp_q.push_back(8'h14); exp_q.push_back(8'h15); exp_q.push_back(8'h20);
    check_pulses("t4");

    // 5: overrun while spacing window is running
    ov0 = ov_cnt;
    send(8'h05);
    step_n(1);
    send(8'h11);
    send(8'h22);
    wait_idle(40); step_n(20);
    check("t5_overrun_count", 32'(ov_cnt - ov0), 32'd1);
    exp_q.push_back(8'h05); exp_q.push_back(8'h22);
    check_pulses("t5");

    // 6: asynchronous reset in the middle of a fade
    send(8'h9F);
    wait_pulses(1, 40);
    step_n(5);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_cmd_out", 32'(cmd_out), 32'h0);
    check("t6_rst_cmd_valid", 32'(cmd_valid), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_overrun", 32'(overrun), 32'h0);
    step_n(2);
    rst = 1'b0;
    clear_q();
    step_n(40);
    check("t6_no_pulse_after_release", 32'(pd_q.size()), 32'd0);
    check("t6_idle_after_release", 32'(busy), 32'd0);
    send(8'h82); wait_idle(60); step_n(10);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    check_pulses("t6_restart_from_zero");

    // Random traffic, including bursts, fades and occasional resets
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) step_n($urandom_range(0, 3));
      else step_n($urandom_range(4, 30));
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
      send(8'($urandom));
    end
    wait_idle(400);
    step_n(5);
    clear_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
